tpu_ctrl: RTL and testbench

Parametrised matrix-job sequencer between the A/B/OUT global buffers and the systolic TPU core. It accepts one job descriptor (M, N, K plus buffer base indices) and streams K operand words from the A and B buffers into the TPU under a full valid/ready handshake. It then drains M result words from the TPU into the output buffer and pulses `out_valid` when the job completes. Word width, buffer depth and dimension width are parameters, and job lengths come from the descriptor rather than being fixed.

---
 rtl/tpu_ctrl_if.sv | 49 ++++
 rtl/tpu_ctrl.sv | 156 +++++++++++++++
 tb/tb_tpu_ctrl.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tpu_ctrl_if.sv
// Job descriptor, global-buffer and TPU-core signals of the matrix-job sequencer.
// master is the controller's view; slave is the buffers/TPU/host view.
interface tpu_ctrl_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned DIM_W  = 6
);
   logic              in_valid;
   logic [DIM_W-1:0]  m;
   logic [DIM_W-1:0]  n;
   logic [DIM_W-1:0]  k;
   logic [ADDR_W-1:0] base_a;
   logic [ADDR_W-1:0] base_b;
   logic [ADDR_W-1:0] base_o;
   logic              busy;
   logic              out_valid;
   logic              err;
   logic [ADDR_W-1:0] gbuf_a_idx;
   logic [ADDR_W-1:0] gbuf_b_idx;
   logic [DATA_W-1:0] gbuf_a_rdata;
   logic [DATA_W-1:0] gbuf_b_rdata;
   logic              tpu_in_valid;
   logic              tpu_in_ready;
   logic [DATA_W-1:0] tpu_a;
   logic [DATA_W-1:0] tpu_b;
   logic [DIM_W-1:0]  tpu_n;
   logic              tpu_out_valid;
   logic [DATA_W-1:0] tpu_out;
   logic              tpu_out_ready;
   logic              gbuf_o_wr_en;
   logic [ADDR_W-1:0] gbuf_o_idx;
   logic [DATA_W-1:0] gbuf_o_wdata;

   modport master (
      input  in_valid, m, n, k, base_a, base_b, base_o,
      input  gbuf_a_rdata, gbuf_b_rdata, tpu_in_ready, tpu_out_valid, tpu_out,
      output busy, out_valid, err, gbuf_a_idx, gbuf_b_idx,
      output tpu_in_valid, tpu_a, tpu_b, tpu_n, tpu_out_ready,
      output gbuf_o_wr_en, gbuf_o_idx, gbuf_o_wdata
   );

   modport slave (
      output in_valid, m, n, k, base_a, base_b, base_o,
      output gbuf_a_rdata, gbuf_b_rdata, tpu_in_ready, tpu_out_valid, tpu_out,
      input  busy, out_valid, err, gbuf_a_idx, gbuf_b_idx,
      input  tpu_in_valid, tpu_a, tpu_b, tpu_n, tpu_out_ready,
      input  gbuf_o_wr_en, gbuf_o_idx, gbuf_o_wdata
   );
endinterface

// File: rtl/tpu_ctrl.sv
// Matrix-job sequencer: streams K operand pairs from the A/B buffers into the TPU,
// then drains M results into the output buffer and signals completion.
module tpu_ctrl #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned DIM_W  = 6
) (
   input logic        clk,
   input logic        rst,
   tpu_ctrl_if.master bus
);
   // rc must be able to reach k even when k exceeds the buffer depth
   localparam int unsigned RC_W = (ADDR_W + 1 > DIM_W) ? ADDR_W + 1 : DIM_W;

   typedef enum logic [1:0] {S_IDLE, S_FEED, S_DRAIN, S_DONE} state_t;

   state_t            state, state_next;
   logic [DIM_W-1:0]  m_q, n_q, k_q, m_d, n_d, k_d;
   logic [ADDR_W-1:0] base_a_q, base_b_q, base_o_q, base_a_d, base_b_d, base_o_d;
   logic              err_q, err_d;
   logic [RC_W-1:0]   rc, rc_d, rd_sel;
   logic [DIM_W-1:0]  fc, fc_d, wc, wc_d;
   logic              pend, pend_d;
   logic              issue, xfer;

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_next;
   end

   // Descriptor and counter registers
   always_ff @(posedge clk) begin
      if (rst) begin
         m_q      <= '0;
         n_q      <= '0;
         k_q      <= '0;
         base_a_q <= '0;
         base_b_q <= '0;
         base_o_q <= '0;
         err_q    <= 1'b0;
         rc       <= '0;
         fc       <= '0;
         wc       <= '0;
         pend     <= 1'b0;
      end else begin
         m_q      <= m_d;
         n_q      <= n_d;
         k_q      <= k_d;
         base_a_q <= base_a_d;
         base_b_q <= base_b_d;
         base_o_q <= base_o_d;
         err_q    <= err_d;
         rc       <= rc_d;
         fc       <= fc_d;
         wc       <= wc_d;
         pend     <= pend_d;
      end
   end

   // Next-state and output decode
   always_comb begin
      state_next = state;
      m_d        = m_q;
      n_d        = n_q;
      k_d        = k_q;
      base_a_d   = base_a_q;
      base_b_d   = base_b_q;
      base_o_d   = base_o_q;
      err_d      = err_q;
      rc_d       = rc;
      fc_d       = fc;
      wc_d       = wc;
      pend_d     = pend;
      issue      = 1'b0;
      xfer       = 1'b0;
      rd_sel     = rc;

      bus.busy          = (state != S_IDLE);
      bus.out_valid     = 1'b0;
      bus.err           = 1'b0;
      bus.gbuf_a_idx    = ADDR_W'(0);
      bus.gbuf_b_idx    = ADDR_W'(0);
      bus.tpu_in_valid  = 1'b0;
      bus.tpu_a         = DATA_W'(0);
      bus.tpu_b         = DATA_W'(0);
      bus.tpu_n         = n_q;
      bus.tpu_out_ready = 1'b0;
      bus.gbuf_o_wr_en  = 1'b0;
      bus.gbuf_o_idx    = ADDR_W'(0);
      bus.gbuf_o_wdata  = DATA_W'(0);

      unique case (state)
         S_IDLE: begin
            if (bus.in_valid) begin
               m_d      = bus.m;
               n_d      = bus.n;
               k_d      = bus.k;
               base_a_d = bus.base_a;
               base_b_d = bus.base_b;
               base_o_d = bus.base_o;
               rc_d     = '0;
               fc_d     = '0;
               wc_d     = '0;
               pend_d   = 1'b0;
               if ((bus.m == DIM_W'(0)) || (bus.k == DIM_W'(0))) begin
                  err_d      = 1'b1;
                  state_next = S_DONE;
               end else begin
                  err_d      = 1'b0;
                  state_next = S_FEED;
               end
            end
         end

         S_FEED: begin
            xfer  = pend && bus.tpu_in_ready;
            issue = (rc < RC_W'(k_q)) && (!pend || xfer);
            // While stalled, keep presenting the index of the pending word
            rd_sel = issue ? rc : (rc - RC_W'(1));
            bus.gbuf_a_idx   = base_a_q + ADDR_W'(rd_sel);
            bus.gbuf_b_idx   = base_b_q + ADDR_W'(rd_sel);
            bus.tpu_in_valid = pend;
            if (pend) begin
               bus.tpu_a = bus.gbuf_a_rdata;
               bus.tpu_b = bus.gbuf_b_rdata;
            end
            if (issue) rc_d = rc + RC_W'(1);
            pend_d = issue || (pend && !xfer);
            if (xfer) begin
               fc_d = fc + DIM_W'(1);
               if (fc == (k_q - DIM_W'(1))) state_next = S_DRAIN;
            end
         end

         S_DRAIN: begin
            bus.tpu_out_ready = 1'b1;
            if (bus.tpu_out_valid && !rst) begin
               bus.gbuf_o_wr_en = 1'b1;
               bus.gbuf_o_idx   = base_o_q + ADDR_W'(wc);
               bus.gbuf_o_wdata = bus.tpu_out;
               wc_d             = wc + DIM_W'(1);
               if (wc == (m_q - DIM_W'(1))) state_next = S_DONE;
            end
         end

         S_DONE: begin
            bus.out_valid = 1'b1;
            bus.err       = err_q;
            state_next    = S_IDLE;
         end

         default: state_next = S_IDLE;
      endcase
   end
endmodule

// File: tb/tb_tpu_ctrl.sv
// Directed bench for tpu_ctrl: nominal, stall, wrap, reject, mid-job reset
// and a 64-bit / 64-deep instance running a k=m=63 job.
module tb_tpu_ctrl;
   localparam int unsigned DW  = 32;
   localparam int unsigned AW  = 5;
   localparam int unsigned MW  = 6;
   localparam int unsigned DW2 = 64;
   localparam int unsigned AW2 = 6;

   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   tpu_ctrl_if #(.DATA_W(DW),  .ADDR_W(AW),  .DIM_W(MW)) bus ();
   tpu_ctrl_if #(.DATA_W(DW2), .ADDR_W(AW2), .DIM_W(MW)) bus2 ();

   tpu_ctrl #(.DATA_W(DW),  .ADDR_W(AW),  .DIM_W(MW)) dut  (.clk(clk), .rst(rst), .bus(bus));
   tpu_ctrl #(.DATA_W(DW2), .ADDR_W(AW2), .DIM_W(MW)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

   logic [DW-1:0]  mem_a  [32];
   logic [DW-1:0]  mem_b  [32];
   logic [DW2-1:0] mem2_a [64];
   logic [DW2-1:0] mem2_b [64];

   function automatic logic [DW-1:0] a_word(input int i);
      return 32'hA000_0000 + 32'(i);
   endfunction
   function automatic logic [DW-1:0] b_word(input int i);
      return 32'hB000_0000 + 32'(i) * 32'd7;
   endfunction
   function automatic logic [DW-1:0] r_word(input int j);
      return 32'h5E50_0000 + 32'(j);
   endfunction
   function automatic logic [DW2-1:0] a2_word(input int i);
      return {32'hC0DE_0000 | 32'(i), 32'(i) * 32'h9E37_79B9};
   endfunction
   function automatic logic [DW2-1:0] b2_word(input int i);
      return {32'(i) * 32'h0101_0101, 32'hFACE_0000 | 32'(i)};
   endfunction
   function automatic logic [DW2-1:0] r2_word(input int j);
      return {~32'(j), 32'h1234_0000 | 32'(j)};
   endfunction

   // Synchronous-read buffer models
   always_ff @(posedge clk) begin
      bus.gbuf_a_rdata  <= mem_a[bus.gbuf_a_idx];
      bus.gbuf_b_rdata  <= mem_b[bus.gbuf_b_idx];
      bus2.gbuf_a_rdata <= mem2_a[bus2.gbuf_a_idx];
      bus2.gbuf_b_rdata <= mem2_b[bus2.gbuf_b_idx];
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_job(input int k, input int m, input int ba, input int bb, input int bo);
      bus.in_valid = 1'b1;
      bus.k        = MW'(k);
      bus.m        = MW'(m);
      bus.n        = MW'(3);
      bus.base_a   = AW'(ba);
      bus.base_b   = AW'(bb);
      bus.base_o   = AW'(bo);
   endtask

   // Full job with tpu_in_ready held high; checks indices, operands, writes, completion
   task automatic run_job(input int k, input int m, input int ba, input int bb, input int bo,
                          input string nm);
      bus.tpu_in_ready = 1'b1;
      start_job(k, m, ba, bb, bo);
      #1;
      chk({nm, "_busy_c0"}, 64'(bus.busy), 64'd0);
      tick();
      bus.in_valid = 1'b0;
      for (int c = 1; c <= k + 1; c++) begin
         #1;
         if (c <= k) begin
            chk({nm, "_aidx"}, 64'(bus.gbuf_a_idx), 64'((ba + c - 1) % 32));
            chk({nm, "_bidx"}, 64'(bus.gbuf_b_idx), 64'((bb + c - 1) % 32));
         end
         if (c == 1) begin
            chk({nm, "_busy_c1"}, 64'(bus.busy), 64'd1);
            chk({nm, "_inv_c1"}, 64'(bus.tpu_in_valid), 64'd0);
         end else begin
            chk({nm, "_inv"}, 64'(bus.tpu_in_valid), 64'd1);
            chk({nm, "_tpu_a"}, 64'(bus.tpu_a), 64'(a_word((ba + c - 2) % 32)));
            chk({nm, "_tpu_b"}, 64'(bus.tpu_b), 64'(b_word((bb + c - 2) % 32)));
         end
         tick();
      end
      for (int j = 0; j < m; j++) begin
         bus.tpu_out_valid = 1'b1;
         bus.tpu_out       = r_word(j);
         #1;
         if (j == 0) begin
            chk({nm, "_inv_drain"}, 64'(bus.tpu_in_valid), 64'd0);
            chk({nm, "_oready"}, 64'(bus.tpu_out_ready), 64'd1);
         end
         chk({nm, "_wr_en"}, 64'(bus.gbuf_o_wr_en), 64'd1);
         chk({nm, "_oidx"}, 64'(bus.gbuf_o_idx), 64'((bo + j) % 32));
         chk({nm, "_wdata"}, 64'(bus.gbuf_o_wdata), 64'(r_word(j)));
         chk({nm, "_no_ov"}, 64'(bus.out_valid), 64'd0);
         tick();
      end
      bus.tpu_out_valid = 1'b0;
      #1;
      chk({nm, "_out_valid"}, 64'(bus.out_valid), 64'd1);
      chk({nm, "_err"}, 64'(bus.err), 64'd0);
      chk({nm, "_wr_done"}, 64'(bus.gbuf_o_wr_en), 64'd0);
      tick();
      chk({nm, "_ov_end"}, 64'(bus.out_valid), 64'd0);
      chk({nm, "_busy_end"}, 64'(bus.busy), 64'd0);
   endtask

   initial begin
      int w;
      logic [DW-1:0] held;
      for (int i = 0; i < 32; i++) begin
         mem_a[i] = a_word(i);
         mem_b[i] = b_word(i);
      end
      for (int i = 0; i < 64; i++) begin
         mem2_a[i] = a2_word(i);
         mem2_b[i] = b2_word(i);
      end
      rst = 1'b1;
      bus.in_valid = 1'b0;  bus.m = '0; bus.n = '0; bus.k = '0;
      bus.base_a = '0; bus.base_b = '0; bus.base_o = '0;
      bus.tpu_in_ready = 1'b0; bus.tpu_out_valid = 1'b0; bus.tpu_out = '0;
      bus2.in_valid = 1'b0; bus2.m = '0; bus2.n = '0; bus2.k = '0;
      bus2.base_a = '0; bus2.base_b = '0; bus2.base_o = '0;
      bus2.tpu_in_ready = 1'b0; bus2.tpu_out_valid = 1'b0; bus2.tpu_out = '0;
      tick();
      tick();
      rst = 1'b0;
      #1;
      chk("rst_busy", 64'(bus.busy), 64'd0);
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_err", 64'(bus.err), 64'd0);
      chk("rst_inv", 64'(bus.tpu_in_valid), 64'd0);
      chk("rst_oready", 64'(bus.tpu_out_ready), 64'd0);
      chk("rst_wr_en", 64'(bus.gbuf_o_wr_en), 64'd0);
      chk("rst_aidx", 64'(bus.gbuf_a_idx), 64'd0);
      tick();

      run_job(4, 4, 0, 0, 0, "nom");

      // Input stall: ready low in cycles 3..5, k=8, m=1
      start_job(8, 1, 0, 0, 0);
      bus.tpu_in_ready = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      tick();
      w = 0;
      held = '0;
      for (int c = 2; c <= 12; c++) begin
         bus.tpu_in_ready = !(c >= 3 && c <= 5);
         #1;
         chk("stall_inv", 64'(bus.tpu_in_valid), 64'd1);
         chk("stall_tpu_a", 64'(bus.tpu_a), 64'(a_word(w)));
         if (c >= 4 && c <= 6) chk("stall_hold", 64'(bus.tpu_a), 64'(held));
         held = a_word(w);
         if (bus.tpu_in_ready) w++;
         tick();
      end
      bus.tpu_in_ready = 1'b1;
      #1;
      chk("stall_feed_end", 64'(bus.tpu_in_valid), 64'd0);
      chk("stall_drain", 64'(bus.tpu_out_ready), 64'd1);
      bus.tpu_out_valid = 1'b1;
      bus.tpu_out = r_word(9);
      #1;
      chk("stall_wdata", 64'(bus.gbuf_o_wdata), 64'(r_word(9)));
      tick();
      bus.tpu_out_valid = 1'b0;
      #1;
      chk("stall_out_valid", 64'(bus.out_valid), 64'd1);
      tick();

      run_job(4, 2, 30, 29, 31, "wrap");

      // Rejected job, k=0 then m=0
      start_job(0, 3, 0, 0, 0);
      tick();
      bus.in_valid = 1'b0;
      #1;
      chk("zk_out_valid", 64'(bus.out_valid), 64'd1);
      chk("zk_err", 64'(bus.err), 64'd1);
      chk("zk_busy", 64'(bus.busy), 64'd1);
      chk("zk_inv", 64'(bus.tpu_in_valid), 64'd0);
      chk("zk_wr", 64'(bus.gbuf_o_wr_en), 64'd0);
      tick();
      chk("zk_busy_after", 64'(bus.busy), 64'd0);
      chk("zk_ov_after", 64'(bus.out_valid), 64'd0);
      start_job(2, 0, 0, 0, 0);
      tick();
      bus.in_valid = 1'b0;
      #1;
      chk("zm_err", 64'(bus.err), 64'd1);
      tick();

      // Mid-DRAIN ignored start and reset
      start_job(2, 3, 0, 0, 0);
      tick();
      bus.in_valid = 1'b0;
      tick();
      tick();
      #1;
      chk("mr_tpu_a", 64'(bus.tpu_a), 64'(a_word(1)));
      tick();
      start_job(0, 0, 5, 5, 5);
      bus.tpu_out_valid = 1'b1;
      bus.tpu_out = r_word(0);
      #1;
      chk("mr_wr0", 64'(bus.gbuf_o_wr_en), 64'd1);
      tick();
      bus.in_valid = 1'b0;
      bus.tpu_out = r_word(1);
      #1;
      chk("mr_ign_busy", 64'(bus.busy), 64'd1);
      chk("mr_ign_ov", 64'(bus.out_valid), 64'd0);
      chk("mr_wr1_idx", 64'(bus.gbuf_o_idx), 64'd1);
      tick();
      rst = 1'b1;
      bus.tpu_out = r_word(2);
      #1;
      chk("mr_rst_nowr", 64'(bus.gbuf_o_wr_en), 64'd0);
      tick();
      rst = 1'b0;
      #1;
      chk("mr_busy", 64'(bus.busy), 64'd0);
      chk("mr_ov", 64'(bus.out_valid), 64'd0);
      chk("mr_err", 64'(bus.err), 64'd0);
      chk("mr_oready", 64'(bus.tpu_out_ready), 64'd0);
      chk("mr_wr", 64'(bus.gbuf_o_wr_en), 64'd0);
      chk("mr_oidx", 64'(bus.gbuf_o_idx), 64'd0);
      chk("mr_wdata", 64'(bus.gbuf_o_wdata), 64'd0);
      bus.tpu_out_valid = 1'b0;
      tick();
      chk("mr_ov_later", 64'(bus.out_valid), 64'd0);

      run_job(3, 2, 4, 9, 10, "post");

      // Wide instance, k=m=63 with wrapped base
      bus2.in_valid = 1'b1;
      bus2.k = MW'(63); bus2.m = MW'(63); bus2.n = MW'(1);
      bus2.base_a = AW2'(5); bus2.base_b = AW2'(40); bus2.base_o = AW2'(1);
      bus2.tpu_in_ready = 1'b1;
      tick();
      bus2.in_valid = 1'b0;
      tick();
      for (int c = 2; c <= 64; c++) begin
         #1;
         chk("sw_inv", 64'(bus2.tpu_in_valid), 64'd1);
         chk("sw_tpu_a", bus2.tpu_a, a2_word((5 + c - 2) % 64));
         chk("sw_tpu_b", bus2.tpu_b, b2_word((40 + c - 2) % 64));
         tick();
      end
      for (int j = 0; j < 63; j++) begin
         bus2.tpu_out_valid = 1'b1;
         bus2.tpu_out = r2_word(j);
         #1;
         chk("sw_wr_en", 64'(bus2.gbuf_o_wr_en), 64'd1);
         chk("sw_oidx", 64'(bus2.gbuf_o_idx), 64'((1 + j) % 64));
         chk("sw_wdata", bus2.gbuf_o_wdata, r2_word(j));
         tick();
      end
      bus2.tpu_out_valid = 1'b0;
      #1;
      chk("sw_out_valid", 64'(bus2.out_valid), 64'd1);
      chk("sw_err", 64'(bus2.err), 64'd0);
      tick();
      chk("sw_busy_end", 64'(bus2.busy), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
